// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// valid/ready requesters; one transaction in flight, response returned to its owner.
module mem_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_gnt
);

  // Handshakes: a transfer happens on a rising CLK edge where valid && ready.
  // req*_ready is combinational on req*_valid (held stable by the requester);
  // rsp*_valid/rdata are registered and held until rsp*_ready of the owner.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic gnt;
  logic accept;
  logic owner_rsp_ready;

  // When both ports ask, the port equal to prio wins; otherwise whoever asks.
  always_comb begin
    gnt    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept = RST && (state_q == IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready      = accept && !gnt;
  assign req1_ready      = accept && gnt;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d    = gnt;
          wr_d       = gnt ? req1_wr : req0_wr;
          addr_d     = gnt ? req1_addr : req0_addr;
          wdata_d    = gnt ? req1_wdata : req0_wdata;
          last_gnt_d = gnt;
          prio_d     = !gnt;
          mem_en_d   = 1'b1;
          mem_wr_d   = gnt ? req1_wr : req0_wr;
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        if (wr_q) begin
          rdata_d              = '0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Memory read data is registered: valid exactly one cycle after ISSUE.
        rdata_d              = mem_rdata;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rsp_valid_d = 2'b00;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      last_gnt_q  <= 1'b0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign last_gnt   = last_gnt_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_valid_q[0] ? rdata_q : '0;
  assign rsp1_rdata = rsp_valid_q[1] ? rdata_q : '0;

endmodule
